// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the shared main-memory arbiter.
// The arbiter attaches through the slave modport; its environment uses master.
interface mem_arbiter_if #(
   parameter int unsigned num_req_p        = 4,
   parameter int unsigned dma_data_width_p = 4,
   parameter int unsigned addr_width_p     = 32
);
   localparam int unsigned id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int unsigned line_width_lp = dma_data_width_p * 32;

   logic [num_req_p-1:0]                     req_valid_i;
   logic [num_req_p-1:0]                     req_ready_o;
   logic [num_req_p-1:0]                     req_we_i;
   logic [num_req_p-1:0][addr_width_p-1:0]   req_addr_i;
   logic [num_req_p-1:0][line_width_lp-1:0]  req_wdata_i;
   logic [num_req_p-1:0]                     resp_valid_o;
   logic [line_width_lp-1:0]                 resp_data_o;

   logic                                     mem_valid_o;
   logic                                     mem_ready_i;
   logic                                     mem_we_o;
   logic [addr_width_p-1:0]                  mem_addr_o;
   logic [line_width_lp-1:0]                 mem_wdata_o;
   logic                                     mem_valid_i;
   logic [line_width_lp-1:0]                 mem_data_i;

   logic                                     busy_o;
   logic [id_width_lp-1:0]                   grant_id_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      input  mem_ready_i, mem_valid_i, mem_data_i,
      output req_ready_o, resp_valid_o, resp_data_o,
      output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output busy_o, grant_id_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      output mem_ready_i, mem_valid_i, mem_data_i,
      input  req_ready_o, resp_valid_o, resp_data_o,
      input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  busy_o, grant_id_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between cache DMA requesters,
// with at most one memory transaction outstanding.
module mem_arbiter #(
   parameter int unsigned num_req_p        = 4,
   parameter int unsigned dma_data_width_p = 4,
   parameter int unsigned addr_width_p     = 32
) (
   input logic          clk_i,
   input logic          reset_i,
   mem_arbiter_if.slave bus
);
   localparam int unsigned id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int unsigned line_width_lp = dma_data_width_p * 32;

   typedef logic [id_width_lp-1:0] id_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                   state_q, state_d;
   id_t                      rr_ptr_q, rr_ptr_d;
   id_t                      grant_id_q, grant_id_d;
   logic                     mem_we_q, mem_we_d;
   logic [addr_width_p-1:0]  mem_addr_q, mem_addr_d;
   logic [line_width_lp-1:0] mem_wdata_q, mem_wdata_d;
   logic [line_width_lp-1:0] resp_data_q, resp_data_d;

   id_t                      sel;
   id_t                      cand;
   logic                     sel_found;
   int unsigned              idx;
   logic [num_req_p-1:0]     req_ready;
   logic [num_req_p-1:0]     resp_valid;

   // First valid requester at or above the pointer, wrapping modulo num_req_p.
   always_comb begin
      sel       = '0;
      cand      = '0;
      sel_found = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= num_req_p) idx = idx - num_req_p;
         cand = id_t'(idx);
         if (!sel_found && bus.req_valid_i[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      resp_data_d = resp_data_q;
      req_ready   = '0;
      resp_valid  = '0;

      case (state_q)
         IDLE: begin
            if (sel_found && !reset_i) begin
               req_ready[sel] = 1'b1;
               grant_id_d     = sel;
               mem_we_d       = bus.req_we_i[sel];
               mem_addr_d     = bus.req_addr_i[sel];
               mem_wdata_d    = bus.req_wdata_i[sel];
               rr_ptr_d       = (sel == id_t'(num_req_p - 1)) ? '0 : sel + 1'b1;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready_i) state_d = mem_we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (bus.mem_valid_i) begin
               resp_data_d = bus.mem_data_i;
               state_d     = RESP;
            end
         end
         RESP: begin
            resp_valid[grant_id_q] = 1'b1;
            state_d                = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_data_o  = resp_data_q;
   assign bus.mem_valid_o  = (state_q == ISSUE);
   assign bus.mem_we_o     = mem_we_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_wdata_o  = mem_wdata_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.grant_id_o   = grant_id_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read/write, round-robin order,
// memory backpressure, spurious memory data and reset abort.
module tb_mem_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_arbiter_if #(.num_req_p(4), .dma_data_width_p(4), .addr_width_p(32)) bus ();

   mem_arbiter #(.num_req_p(4), .dma_data_width_p(4), .addr_width_p(32)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [127:0] rd_line;
   logic [127:0] wr_line;
   logic [127:0] last_line;
   logic [127:0] bp_line;
   int unsigned  e;

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.req_valid_i = '0;
      bus.req_we_i    = '0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.mem_ready_i = 1'b1;
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = '0;
      rd_line   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      wr_line   = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      bp_line   = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;
      last_line = '0;

      // Reset state, with requests present that must not be accepted.
      tick();
      bus.req_valid_i = 4'b1111;
      #1;
      check("rst_ready", bus.req_ready_o, 4'b0000);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_mem_valid", bus.mem_valid_o, 1'b0);
      check("rst_resp_valid", bus.resp_valid_o, 4'b0000);
      check("rst_grant", bus.grant_id_o, 2'd0);
      bus.req_valid_i = '0;
      tick();
      rst = 1'b0;
      tick();

      // Single read: req0 @ 0x40, memory data at T+2.
      bus.req_valid_i   = 4'b0001;
      bus.req_we_i      = 4'b0000;
      bus.req_addr_i[0] = 32'h40;
      #1;
      check("rd_ready_T", bus.req_ready_o, 4'b0001);
      tick();
      bus.req_valid_i = '0;
      #1;
      check("rd_mem_valid_T1", bus.mem_valid_o, 1'b1);
      check("rd_mem_we_T1", bus.mem_we_o, 1'b0);
      check("rd_mem_addr_T1", bus.mem_addr_o, 32'h40);
      check("rd_ready_T1", bus.req_ready_o, 4'b0000);
      tick();
      check("rd_mem_valid_T2", bus.mem_valid_o, 1'b0);
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = rd_line;
      tick();
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = '0;
      #1;
      check("rd_resp_valid_T3", bus.resp_valid_o, 4'b0001);
      check("rd_resp_data_T3", bus.resp_data_o, rd_line);
      tick();
      check("rd_busy_T4", bus.busy_o, 1'b0);
      check("rd_resp_valid_T4", bus.resp_valid_o, 4'b0000);

      // Single write: req2 @ 0x80.
      bus.req_valid_i    = 4'b0100;
      bus.req_we_i       = 4'b0100;
      bus.req_addr_i[2]  = 32'h80;
      bus.req_wdata_i[2] = wr_line;
      #1;
      check("wr_ready_T", bus.req_ready_o, 4'b0100);
      tick();
      bus.req_valid_i = '0;
      #1;
      check("wr_mem_valid_T1", bus.mem_valid_o, 1'b1);
      check("wr_mem_we_T1", bus.mem_we_o, 1'b1);
      check("wr_mem_addr_T1", bus.mem_addr_o, 32'h80);
      check("wr_mem_wdata_T1", bus.mem_wdata_o, wr_line);
      check("wr_grant_T1", bus.grant_id_o, 2'd2);
      tick();
      check("wr_resp_valid_T2", bus.resp_valid_o, 4'b0100);
      check("wr_resp_data_hold", bus.resp_data_o, rd_line);
      tick();
      check("wr_busy_T3", bus.busy_o, 1'b0);

      // Round-robin: pointer now at 3, all four hold reads.
      bus.req_we_i = '0;
      for (int i = 0; i < 4; i++) bus.req_addr_i[i] = 32'h1000 + 32'(i) * 32'h40;
      bus.req_valid_i = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         e = (3 + g) % 4;
         #1;
         check("rr_ready", bus.req_ready_o, 4'b0001 << e);
         tick();
         check("rr_grant", bus.grant_id_o, e);
         check("rr_mem_addr", bus.mem_addr_o, 32'h1000 + e * 32'h40);
         check("rr_ready_busy", bus.req_ready_o, 4'b0000);
         tick();
         last_line       = {4{32'hA000_0000 + 32'(g)}};
         bus.mem_valid_i = 1'b1;
         bus.mem_data_i  = last_line;
         tick();
         bus.mem_valid_i = 1'b0;
         #1;
         check("rr_resp_valid", bus.resp_valid_o, 4'b0001 << e);
         check("rr_resp_data", bus.resp_data_o, last_line);
         tick();
      end
      bus.req_valid_i = '0;
      #1;

      // Backpressure: req1 write, mem_ready low for 3 ISSUE cycles.
      bus.req_valid_i    = 4'b0010;
      bus.req_we_i       = 4'b0010;
      bus.req_addr_i[1]  = 32'h0000_0C00;
      bus.req_wdata_i[1] = bp_line;
      bus.mem_ready_i    = 1'b0;
      #1;
      check("bp_ready_T", bus.req_ready_o, 4'b0010);
      tick();
      bus.req_valid_i = '0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus.mem_ready_i = 1'b1;
         #1;
         check("bp_mem_valid", bus.mem_valid_o, 1'b1);
         check("bp_mem_we", bus.mem_we_o, 1'b1);
         check("bp_mem_addr", bus.mem_addr_o, 32'h0000_0C00);
         check("bp_mem_wdata", bus.mem_wdata_o, bp_line);
         check("bp_resp_early", bus.resp_valid_o, 4'b0000);
         tick();
      end
      check("bp_resp_valid_T5", bus.resp_valid_o, 4'b0010);
      tick();
      check("bp_busy_T6", bus.busy_o, 1'b0);

      // Spurious memory data in IDLE must be ignored.
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = {4{32'h5555_5555}};
      tick();
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = '0;
      #1;
      check("sp_resp_valid", bus.resp_valid_o, 4'b0000);
      check("sp_busy", bus.busy_o, 1'b0);
      check("sp_resp_data", bus.resp_data_o, last_line);

      // Reset during WAIT aborts the read; next grant goes to req0.
      bus.req_valid_i   = 4'b1000;
      bus.req_we_i      = '0;
      bus.req_addr_i[3] = 32'h0000_0F00;
      #1;
      check("ab_ready_T", bus.req_ready_o, 4'b1000);
      tick();
      bus.req_valid_i = '0;
      tick();
      tick();
      check("ab_busy_wait", bus.busy_o, 1'b1);
      rst             = 1'b1;
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = {4{32'h7777_7777}};
      tick();
      rst             = 1'b0;
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = '0;
      #1;
      check("ab_resp_valid", bus.resp_valid_o, 4'b0000);
      check("ab_mem_valid", bus.mem_valid_o, 1'b0);
      check("ab_busy", bus.busy_o, 1'b0);
      check("ab_grant", bus.grant_id_o, 2'd0);
      check("ab_mem_addr", bus.mem_addr_o, 32'h0);
      check("ab_mem_we", bus.mem_we_o, 1'b0);
      check("ab_mem_wdata", bus.mem_wdata_o, 128'h0);
      check("ab_resp_data", bus.resp_data_o, 128'h0);
      bus.req_valid_i = 4'b1111;
      #1;
      check("ab_next_ready", bus.req_ready_o, 4'b0001);
      tick();
      bus.req_valid_i = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
